// File: rtl/comm_pkg.sv
// ---------------------------------------------------------------------------
// comm_pkg
//  Shared definitions for the framed serial link (transmit-side framer and
//  receive-side frame_sync_deserializer).
//  Contents:
//   sync_state_t        receiver alignment states (HUNT, VERIFY, LOCKED)
//   *_DEFAULT           default sample width, sync width, sync word and
//                       samples per frame used by both ends of the link
//   frame_len()         total bits per frame (sync + payload)
// ---------------------------------------------------------------------------
package comm_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    localparam int         DATA_W_DEFAULT            = 8;
    localparam int         SYNC_W_DEFAULT            = 8;
    localparam logic [7:0] SYNC_WORD_DEFAULT         = 8'hA7;
    localparam int         SAMPLES_PER_FRAME_DEFAULT = 4;

    function automatic int frame_len(input int sync_w, input int data_w, input int samples);
        return sync_w + samples * data_w;
    endfunction

endpackage

// File: rtl/sync_word_detector.sv
// ---------------------------------------------------------------------------
// sync_word_detector
//  Sliding SYNC_W-bit shift register with an equality compare against the
//  frame sync word.
//  Ports:
//   clk        in   clock
//   reset      in   asynchronous active-low reset (clears the shift register)
//   bit_in     in   serial bit, MSB of the word first
//   bit_valid  in   shift enable; bit_in is consumed only when high
//   match      out  high on a valid-bit cycle when the word formed by the
//                   bit being consumed plus the previous SYNC_W-1 bits
//                   equals SYNC_WORD
// ---------------------------------------------------------------------------
module sync_word_detector #(
    parameter int                SYNC_W    = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hA7
) (
    input  logic clk,
    input  logic reset,
    input  logic bit_in,
    input  logic bit_valid,
    output logic match
);

    logic [SYNC_W-1:0] sr_reg;
    logic [SYNC_W-1:0] sr_next;

    assign sr_next = {sr_reg[SYNC_W-2:0], bit_in};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_reg <= '0;
        end else if (bit_valid) begin
            sr_reg <= sr_next;
        end
    end

    // Compare the post-shift word so the FSM can act on the same edge that
    // consumes the final sync bit.
    assign match = bit_valid && (sr_next == SYNC_WORD);

endmodule

// File: rtl/frame_sync_deserializer.sv
// ---------------------------------------------------------------------------
// frame_sync_deserializer
//  Hunts for the sync word in the decoded bit stream, confirms alignment over
//  CONFIRM consecutive syncs, then assembles MSB-first payload samples.
//  While locked, bad syncs are tolerated (flywheel) until LOCK_MISS_MAX
//  consecutive misses, which drops back to hunting.
//  Frame: SYNC_W sync bits followed by SAMPLES_PER_FRAME x DATA_W payload bits.
//  Ports:
//   clk           in   bit-domain clock
//   reset         in   asynchronous active-low reset
//   bit_in        in   decoded serial bit
//   bit_valid     in   bit_in qualifier
//   sample_out    out  last assembled sample (raw bits, signed by MSB)
//   sample_valid  out  one-clock pulse when sample_out updates
//   locked        out  frame alignment established
//   sync_err      out  one-clock pulse on a sync mismatch while locked
// ---------------------------------------------------------------------------
module frame_sync_deserializer
    import comm_pkg::*;
#(
    parameter int                DATA_W            = DATA_W_DEFAULT,
    parameter int                SYNC_W            = SYNC_W_DEFAULT,
    parameter logic [SYNC_W-1:0] SYNC_WORD         = SYNC_W'(SYNC_WORD_DEFAULT),
    parameter int                SAMPLES_PER_FRAME = SAMPLES_PER_FRAME_DEFAULT,
    parameter int                CONFIRM           = 2,
    parameter int                LOCK_MISS_MAX     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              locked,
    output logic              sync_err
);

    localparam int FRAME_LEN   = frame_len(SYNC_W, DATA_W, SAMPLES_PER_FRAME);
    localparam int PAYLOAD_LEN = SAMPLES_PER_FRAME * DATA_W;
    localparam int CNT_W       = $clog2(FRAME_LEN);
    localparam int SB_W        = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int GOOD_W      = $clog2(CONFIRM + 1);
    localparam int MISS_W      = $clog2(LOCK_MISS_MAX + 1);

    localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  PAYLOAD_END = CNT_W'(PAYLOAD_LEN);
    localparam logic [SB_W-1:0]   SAMPLE_LAST = SB_W'(DATA_W - 1);
    localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(CONFIRM);
    localparam logic [MISS_W-1:0] MISS_LIMIT  = MISS_W'(LOCK_MISS_MAX);

    sync_state_t        state_reg,        state_next;
    logic [CNT_W-1:0]   bit_cnt_reg,      bit_cnt_next;
    logic [SB_W-1:0]    samp_bit_reg,     samp_bit_next;
    logic [GOOD_W-1:0]  good_cnt_reg,     good_cnt_next;
    logic [MISS_W-1:0]  miss_cnt_reg,     miss_cnt_next;
    logic [DATA_W-1:0]  data_reg,         data_next;
    logic [DATA_W-1:0]  sample_out_reg,   sample_out_next;
    logic               sample_valid_reg, sample_valid_next;
    logic               locked_reg,       locked_next;
    logic               sync_err_reg,     sync_err_next;

    logic               match;
    logic               in_payload;
    logic               sync_end;
    logic [CNT_W-1:0]   bit_cnt_inc;
    logic [SB_W-1:0]    samp_bit_inc;
    logic [GOOD_W-1:0]  good_inc;
    logic [MISS_W-1:0]  miss_inc;

    sync_word_detector #(
        .SYNC_W    (SYNC_W),
        .SYNC_WORD (SYNC_WORD)
    ) u_detector (
        .clk       (clk),
        .reset     (reset),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .match     (match)
    );

    // bit_cnt runs 0..PAYLOAD_LEN-1 over the payload and the remainder over
    // the sync slot, so the sync compare and sample emit can never coincide.
    assign in_payload   = (bit_cnt_reg < PAYLOAD_END);
    assign sync_end     = (bit_cnt_reg == LAST_BIT);
    assign bit_cnt_inc  = sync_end ? '0 : bit_cnt_reg + CNT_W'(1);
    assign samp_bit_inc = (samp_bit_reg == SAMPLE_LAST) ? '0 : samp_bit_reg + SB_W'(1);
    assign good_inc     = good_cnt_reg + GOOD_W'(1);
    assign miss_inc     = miss_cnt_reg + MISS_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= HUNT;
            bit_cnt_reg      <= '0;
            samp_bit_reg     <= '0;
            good_cnt_reg     <= '0;
            miss_cnt_reg     <= '0;
            data_reg         <= '0;
            sample_out_reg   <= '0;
            sample_valid_reg <= 1'b0;
            locked_reg       <= 1'b0;
            sync_err_reg     <= 1'b0;
        end else begin
            state_reg        <= state_next;
            bit_cnt_reg      <= bit_cnt_next;
            samp_bit_reg     <= samp_bit_next;
            good_cnt_reg     <= good_cnt_next;
            miss_cnt_reg     <= miss_cnt_next;
            data_reg         <= data_next;
            sample_out_reg   <= sample_out_next;
            sample_valid_reg <= sample_valid_next;
            locked_reg       <= locked_next;
            sync_err_reg     <= sync_err_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        bit_cnt_next      = bit_cnt_reg;
        samp_bit_next     = samp_bit_reg;
        good_cnt_next     = good_cnt_reg;
        miss_cnt_next     = miss_cnt_reg;
        data_next         = data_reg;
        sample_out_next   = sample_out_reg;
        sample_valid_next = 1'b0;
        locked_next       = locked_reg;
        sync_err_next     = 1'b0;

        if (bit_valid) begin
            case (state_reg)
                HUNT: begin
                    if (match) begin
                        bit_cnt_next  = '0;
                        samp_bit_next = '0;
                        miss_cnt_next = '0;
                        good_cnt_next = GOOD_W'(1);
                        // A single-hit confirmation locks straight away.
                        if (GOOD_TARGET <= GOOD_W'(1)) begin
                            state_next  = LOCKED;
                            locked_next = 1'b1;
                        end else begin
                            state_next  = VERIFY;
                        end
                    end
                end

                VERIFY: begin
                    bit_cnt_next = bit_cnt_inc;
                    if (sync_end) begin
                        samp_bit_next = '0;
                        if (match) begin
                            good_cnt_next = good_inc;
                            if (good_inc >= GOOD_TARGET) begin
                                state_next    = LOCKED;
                                locked_next   = 1'b1;
                                miss_cnt_next = '0;
                            end
                        end else begin
                            // The detector keeps sliding, so the bit just
                            // consumed already takes part in the next hunt.
                            state_next    = HUNT;
                            good_cnt_next = '0;
                            bit_cnt_next  = '0;
                        end
                    end
                end

                LOCKED: begin
                    bit_cnt_next = bit_cnt_inc;
                    if (in_payload) begin
                        data_next     = {data_reg[DATA_W-2:0], bit_in};
                        samp_bit_next = samp_bit_inc;
                        if (samp_bit_reg == SAMPLE_LAST) begin
                            sample_out_next   = {data_reg[DATA_W-2:0], bit_in};
                            sample_valid_next = 1'b1;
                        end
                    end
                    if (sync_end) begin
                        samp_bit_next = '0;
                        if (match) begin
                            miss_cnt_next = '0;
                        end else begin
                            sync_err_next = 1'b1;
                            if (miss_inc >= MISS_LIMIT) begin
                                state_next    = HUNT;
                                locked_next   = 1'b0;
                                bit_cnt_next  = '0;
                                good_cnt_next = '0;
                                miss_cnt_next = '0;
                            end else begin
                                // Flywheel: keep frame timing through the miss.
                                miss_cnt_next = miss_inc;
                            end
                        end
                    end
                end

                default: begin
                    state_next    = HUNT;
                    locked_next   = 1'b0;
                    bit_cnt_next  = '0;
                    good_cnt_next = '0;
                    miss_cnt_next = '0;
                end
            endcase
        end
    end

    assign sample_out   = sample_out_reg;
    assign sample_valid = sample_valid_reg;
    assign locked       = locked_reg;
    assign sync_err     = sync_err_reg;

endmodule
